// File: rtl/counter_run_arbiter.sv
// Round-robin owner of one shared WIDTH-bit up-counter. Each grant runs the counter
// for a fixed length or free-runs until the owner drops req.
module counter_run_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   len,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [WIDTH-1:0]           counter_out,
  output logic [NUM_REQ-1:0]         done,
  output logic                       abort_out,
  output logic                       overflow_out
);

  localparam int LW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     counter_q, counter_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 abort_q, abort_d;
  logic                 ovf_q, ovf_d;
  logic [LW-1:0]        last_q, last_d;
  logic [WIDTH-1:0]     target_q, target_d;

  logic                 found;
  logic [LW-1:0]        win;
  int                   idx;
  logic                 owner_req, at_target, free_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      counter_q <= '0;
      done_q    <= '0;
      abort_q   <= 1'b0;
      ovf_q     <= 1'b0;
      last_q    <= LW'(NUM_REQ-1);
      target_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      counter_q <= counter_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      ovf_q     <= ovf_d;
      last_q    <= last_d;
      target_q  <= target_d;
    end
  end

  // Search starts just past the previous owner, so it has lowest priority next time.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[LW-1:0];
      end
    end
  end

  // last_q doubles as the current owner index while in COUNT.
  assign owner_req = req[last_q];
  assign at_target = (counter_q == target_q);
  assign free_run  = (target_q == '0);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (found) state_d = COUNT;
      COUNT: begin
        if (free_run) begin
          if (!owner_req) state_d = IDLE;
        end else if (at_target || !owner_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d   = grant_q;
    busy_d    = busy_q;
    counter_d = counter_q;
    done_d    = '0;
    abort_d   = 1'b0;
    ovf_d     = ovf_q;
    last_d    = last_q;
    target_d  = target_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          busy_d       = 1'b1;
          counter_d    = '0;
          ovf_d        = 1'b0;
          target_d     = len[win*WIDTH +: WIDTH];
          last_d       = win;
        end
      end
      COUNT: begin
        if (free_run) begin
          if (!owner_req) begin
            done_d[last_q] = 1'b1;
            grant_d        = '0;
            busy_d         = 1'b0;
          end else begin
            counter_d = counter_q + 1'b1;
            if (counter_q == '1) ovf_d = 1'b1;
          end
        end else if (at_target) begin
          // Completion wins over a same-cycle req drop.
          done_d[last_q] = 1'b1;
          grant_d        = '0;
          busy_d         = 1'b0;
        end else if (!owner_req) begin
          abort_d = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          counter_d = counter_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign grant        = grant_q;
  assign busy         = busy_q;
  assign counter_out  = counter_q;
  assign done         = done_q;
  assign abort_out    = abort_q;
  assign overflow_out = ovf_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed bench for counter_run_arbiter: single run, round-robin, free-run
// overflow, abort vs done at target, and asynchronous reset mid-run.
module tb_counter_run_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  grant;
  logic        busy;
  logic [3:0]  counter_out;
  logic [3:0]  done;
  logic        abort_out;
  logic        overflow_out;

  int tests = 0;
  int fails = 0;

  counter_run_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
    .clk(clk), .reset(reset), .req(req), .len(len), .grant(grant), .busy(busy),
    .counter_out(counter_out), .done(done), .abort_out(abort_out),
    .overflow_out(overflow_out)
  );

  always #5 clk = ~clk;

  // Advance one edge, sample 1 time unit later; also checks pulse exclusivity.
  task automatic tick();
    @(posedge clk);
    #1;
    tests++;
    if ((done != 0 || abort_out) && (grant != 0 || (done != 0 && abort_out))) begin
      fails++;
      $display("FAIL excl: done=%b abort=%b grant=%b", done, abort_out, grant);
    end
  endtask

  task automatic apply_reset();
    req = '0;
    len = '0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req = '0;
    len = '0;
    reset = 1'b1;
    #3;
    tests++;
    if (grant !== 4'b0 || busy !== 1'b0 || counter_out !== 4'd0 || done !== 4'b0 ||
        abort_out !== 1'b0 || overflow_out !== 1'b0) begin
      fails++;
      $display("FAIL reset: g=%b b=%b c=%0d d=%b a=%b o=%b, want all 0",
               grant, busy, counter_out, done, abort_out, overflow_out);
    end
    #9;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single();
    len[3:0] = 4'd3;
    req = 4'b0001;
    for (int i = 0; i <= 3; i++) begin
      tick();
      tests++;
      if (grant !== 4'b0001 || busy !== 1'b1 || counter_out !== 4'(i)) begin
        fails++;
        $display("FAIL single_run[%0d]: g=%b b=%b c=%0d, want g=0001 b=1 c=%0d",
                 i, grant, busy, counter_out, i);
      end
    end
    req = 4'b0000;
    tick();
    tests++;
    if (done !== 4'b0001 || grant !== 4'b0 || busy !== 1'b0 || overflow_out !== 1'b0 ||
        counter_out !== 4'd3) begin
      fails++;
      $display("FAIL single_done: d=%b g=%b b=%b o=%b c=%0d, want d=0001 g=0 b=0 o=0 c=3",
               done, grant, busy, overflow_out, counter_out);
    end
    tick();
    tests++;
    if (done !== 4'b0) begin
      fails++;
      $display("FAIL single_pulse: d=%b, want 0000", done);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    apply_reset();
    len = {4'd1, 4'd1, 4'd1, 4'd1};
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp_g = 4'b0001 << (r % 4);
      for (int c = 0; c <= 1; c++) begin
        tick();
        tests++;
        if (grant !== exp_g || counter_out !== 4'(c) || done !== 4'b0) begin
          fails++;
          $display("FAIL rr_grant[%0d.%0d]: g=%b c=%0d d=%b, want g=%b c=%0d d=0000",
                   r, c, grant, counter_out, done, exp_g, c);
        end
      end
      if (r == 4) req = 4'b0000;
      tick();
      tests++;
      if (done !== exp_g || grant !== 4'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rr_done[%0d]: d=%b g=%b b=%b, want d=%b g=0000 b=0",
                 r, done, grant, busy, exp_g);
      end
    end
    tick();
  endtask

  task automatic test_free_run();
    len = '0;
    req = 4'b0100;
    for (int k = 0; k < 20; k++) begin
      tick();
      tests++;
      if (grant !== 4'b0100 || counter_out !== 4'(k % 16) || overflow_out !== (k >= 16)) begin
        fails++;
        $display("FAIL free_run[%0d]: g=%b c=%0d o=%b, want g=0100 c=%0d o=%0d",
                 k, grant, counter_out, overflow_out, k % 16, k >= 16);
      end
    end
    req = 4'b0000;
    tick();
    tests++;
    if (done !== 4'b0100 || grant !== 4'b0 || overflow_out !== 1'b1) begin
      fails++;
      $display("FAIL free_done: d=%b g=%b o=%b, want d=0100 g=0000 o=1",
               done, grant, overflow_out);
    end
    len[3:0] = 4'd1;
    req = 4'b0001;
    tick();
    tests++;
    if (grant !== 4'b0001 || overflow_out !== 1'b0 || counter_out !== 4'd0) begin
      fails++;
      $display("FAIL free_regrant: g=%b o=%b c=%0d, want g=0001 o=0 c=0",
               grant, overflow_out, counter_out);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_abort();
    len = '0;
    len[7:4] = 4'd8;
    req = 4'b0010;
    for (int k = 0; k <= 4; k++) tick();
    tests++;
    if (counter_out !== 4'd4 || grant !== 4'b0010) begin
      fails++;
      $display("FAIL abort_pre: c=%0d g=%b, want c=4 g=0010", counter_out, grant);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (abort_out !== 1'b1 || done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_pulse: a=%b d=%b g=%b b=%b, want a=1 d=0000 g=0000 b=0",
               abort_out, done, grant, busy);
    end
    tick();
    tests++;
    if (abort_out !== 1'b0) begin
      fails++;
      $display("FAIL abort_clear: a=%b, want 0", abort_out);
    end
    req = 4'b0010;
    for (int k = 0; k <= 8; k++) tick();
    tests++;
    if (counter_out !== 4'd8 || grant !== 4'b0010) begin
      fails++;
      $display("FAIL target_pre: c=%0d g=%b, want c=8 g=0010", counter_out, grant);
    end
    req = 4'b0000;
    tick();
    tests++;
    if (done !== 4'b0010 || abort_out !== 1'b0 || grant !== 4'b0) begin
      fails++;
      $display("FAIL target_drop: d=%b a=%b g=%b, want d=0010 a=0 g=0000",
               done, abort_out, grant);
    end
    tick();
  endtask

  task automatic test_async_reset();
    len = '0;
    len[7:4] = 4'd8;
    req = 4'b0010;
    for (int k = 0; k <= 5; k++) tick();
    tests++;
    if (counter_out !== 4'd5) begin
      fails++;
      $display("FAIL areset_pre: c=%0d, want 5", counter_out);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (grant !== 4'b0 || busy !== 1'b0 || counter_out !== 4'd0 || done !== 4'b0 ||
        abort_out !== 1'b0 || overflow_out !== 1'b0) begin
      fails++;
      $display("FAIL areset: g=%b b=%b c=%0d d=%b a=%b o=%b, want all 0",
               grant, busy, counter_out, done, abort_out, overflow_out);
    end
    req = 4'b1010;
    #1;
    reset = 1'b0;
    tick();
    tests++;
    if (grant !== 4'b0010 || counter_out !== 4'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL areset_regrant: g=%b c=%0d b=%b, want g=0010 c=0 b=1",
               grant, counter_out, busy);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req = '0;
    len = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_free_run();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
